// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle for one pipeline stage: upstream (in_*) and downstream (out_*) sides.
// The stage itself connects through the slave modport; the driving environment uses master.
interface pipe_stage_reg_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline register with valid/ready handshake, flush and reset payload value.
// Define PIPE_STAGE_SKID_EN to add a skid entry and a registered in_ready.
module pipe_stage_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  pipe_stage_reg_if.slave   bus,
  output logic [1:0]        count
);

  logic [WIDTH-1:0] main_q, main_d;
  logic             main_valid_q, main_valid_d;
  logic [1:0]       count_q, count_d;
  logic             in_fire;
  logic             out_fire;

`ifdef PIPE_STAGE_SKID_EN
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_ready_q, in_ready_d;

  // in_ready comes straight from a flop, so out_ready never reaches upstream combinationally
  assign bus.in_ready = in_ready_q;
`else
  assign bus.in_ready = ~main_valid_q | bus.out_ready;
`endif

  assign in_fire       = bus.in_valid & bus.in_ready;
  assign out_fire      = main_valid_q & bus.out_ready;
  assign bus.out_valid = main_valid_q;
  assign bus.out_data  = main_q;
  assign count         = count_q;

  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    // Payloads are left untouched on flush; only the valid bits drop
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_fire && skid_valid_q) begin
      main_d       = skid_q;
      skid_valid_d = 1'b0;
    end else if (in_fire) begin
      if (!main_valid_q || out_fire) begin
        main_d       = bus.in_data;
        main_valid_d = 1'b1;
      end else begin
        skid_d       = bus.in_data;
        skid_valid_d = 1'b1;
      end
    end else if (out_fire) begin
      main_valid_d = 1'b0;
    end
    in_ready_d = ~skid_valid_d;
    count_d    = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
`else
    if (flush) begin
      main_valid_d = 1'b0;
    end else if (in_fire) begin
      main_d       = bus.in_data;
      main_valid_d = 1'b1;
    end else if (out_fire) begin
      main_valid_d = 1'b0;
    end
    count_d = {1'b0, main_valid_d};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= RESET_VAL;
      main_valid_q <= 1'b0;
      count_q      <= 2'd0;
`ifdef PIPE_STAGE_SKID_EN
      skid_q       <= RESET_VAL;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
`endif
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
      count_q      <= count_d;
`ifdef PIPE_STAGE_SKID_EN
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
`endif
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: queue model checked every cycle plus directed literal checks.
// Builds for either configuration of PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;

  localparam logic [31:0] RV = 32'hDEAD_BEEF;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [1:0] count;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.WIDTH(32)) bus ();

  pipe_stage_reg #(
    .WIDTH    (32),
    .RESET_VAL(RV)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus),
    .count(count)
  );

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [31:0] mq[$];
  bit          model_ok   = 1'b0;
  bit          stall_prev = 1'b0;
  bit          stall_chk  = 1'b0;
  logic [31:0] data_prev  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // A stage of CAP entries: with a skid it accepts whenever not full; without, when empty or draining
  function automatic bit model_ready();
`ifdef PIPE_STAGE_SKID_EN
    return mq.size() < CAP;
`else
    return (mq.size() == 0) || (bus.out_ready == 1'b1);
`endif
  endfunction

  always @(posedge clk) begin : model
    bit inf;
    bit outf;
    inf       = (bus.in_valid == 1'b1) && model_ready();
    outf      = (mq.size() != 0) && (bus.out_ready == 1'b1);
    stall_chk = stall_prev && (rst == 1'b0) && (flush == 1'b0);
    if (rst) begin
      mq.delete();
      model_ok = 1'b1;
    end else if (flush) begin
      mq.delete();
    end else begin
      if (outf) void'(mq.pop_front());
      if (inf) mq.push_back(bus.in_data);
    end
  end

  always @(negedge clk) begin : compare
    if (model_ok) begin
      check("m_out_valid", {31'b0, bus.out_valid}, (mq.size() != 0) ? 32'd1 : 32'd0);
      check("m_count", {30'b0, count}, mq.size());
      check("m_in_ready", {31'b0, bus.in_ready}, model_ready() ? 32'd1 : 32'd0);
      if (mq.size() != 0) check("m_out_data", bus.out_data, mq[0]);
      if (stall_chk) check("m_stall_hold", bus.out_data, data_prev);
      stall_prev = (bus.out_valid == 1'b1) && (bus.out_ready == 1'b0);
      data_prev  = bus.out_data;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, {31'b0, bus.out_valid}, 32'd0);
    check({tag, "_count"}, {30'b0, count}, 32'd0);
    check({tag, "_out_data"}, bus.out_data, RV);
    check({tag, "_in_ready"}, {31'b0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // T1 reset
    cyc();
    cyc();
    check_reset_state("t1_rst");
    $display("[TB] T1 reset held 2 cycles out_data=%h", bus.out_data);
    rst = 1'b0;
    cyc();
    check_reset_state("t1_idle");
    $display("[TB] T1 idle after reset out_data=%h", bus.out_data);

    // T2 streaming
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = i;
      cyc();
      check("t2_out_valid", {31'b0, bus.out_valid}, 32'd1);
      check("t2_out_data", bus.out_data, i);
      check("t2_in_ready", {31'b0, bus.in_ready}, 32'd1);
      $display("[TB] T2 beat %0d out_data=%h", i, bus.out_data);
    end
    bus.in_valid = 1'b0;
    cyc();
    check("t2_drained", {31'b0, bus.out_valid}, 32'd0);

    // T3 backpressure
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h0000_00A1;
    cyc();
    check("t3_load_a1", bus.out_data, 32'h0000_00A1);
    check("t3_count1", {30'b0, count}, 32'd1);
    bus.in_data = 32'h0000_00A2;
    #1;
    check("t3_offer_ready", {31'b0, bus.in_ready}, (CAP == 2) ? 32'd1 : 32'd0);
    cyc();
    check("t3_stall_a1", bus.out_data, 32'h0000_00A1);
    check("t3_count_full", {30'b0, count}, (CAP == 2) ? 32'd2 : 32'd1);
    check("t3_in_ready_full", {31'b0, bus.in_ready}, 32'd0);
    $display("[TB] T3 stalled out_data=%h count=%0d", bus.out_data, count);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cyc();
    if (CAP == 2) begin
      check("t3_a2_next", bus.out_data, 32'h0000_00A2);
      check("t3_count_after1", {30'b0, count}, 32'd1);
      $display("[TB] T3 A1 delivered, out_data=%h", bus.out_data);
      cyc();
    end
    check("t3_empty", {30'b0, count}, 32'd0);
    $display("[TB] T3 drained count=%0d", count);

    // T4 flush
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h0000_0011;
    cyc();
    if (CAP == 2) begin
      bus.in_data = 32'h0000_0022;
      cyc();
    end
    check("t4_full", {30'b0, count}, CAP);
    flush       = 1'b1;
    bus.in_data = 32'h0000_0055;
    cyc();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    check("t4_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("t4_count", {30'b0, count}, 32'd0);
    check("t4_in_ready", {31'b0, bus.in_ready}, 32'd1);
    $display("[TB] T4 flush count=%0d out_valid=%0d", count, bus.out_valid);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t4_no_55", (bus.out_valid == 1'b1 && bus.out_data == 32'h55) ? 32'd1 : 32'd0, 32'd0);
    end

    // T5 reset together with flush and in_fire
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h0000_0033;
    cyc();
    if (CAP == 2) begin
      bus.in_data = 32'h0000_0044;
      cyc();
    end
    rst           = 1'b1;
    flush         = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_data   = 32'h0000_0077;
    cyc();
    check_reset_state("t5_rst");
    $display("[TB] T5 reset mid-operation out_data=%h", bus.out_data);
    rst         = 1'b0;
    flush       = 1'b0;
    bus.in_data = 32'h0000_0099;
    cyc();
    check("t5_first_valid", {31'b0, bus.out_valid}, 32'd1);
    check("t5_first_data", bus.out_data, 32'h0000_0099);
    $display("[TB] T5 first beat after reset out_data=%h", bus.out_data);
    bus.in_valid = 1'b0;
    cyc();

    // T6 random traffic, checked by the model every cycle
    for (int i = 0; i < 10000; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_data   = $urandom;
      bus.out_ready = 1'($urandom_range(0, 1));
      cyc();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cyc();
    cyc();
    cyc();
    check("t6_final_empty", {30'b0, count}, 32'd0);
    $display("[TB] T6 random traffic complete");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
